mem_write_monitor: RTL
======================

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning data_adr width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning write_data width.
REQ-003 The block SHALL have parameter PASS_ADR, default 100, meaning the write address that ends the test with a pass.
REQ-004 The block SHALL have parameter PASS_DATA, default 25, meaning the data required at PASS_ADR.
REQ-005 The block SHALL have parameter SCR_BASE, default 96, and SCR_SIZE, default 4, meaning the allowed scratch window [SCR_BASE, SCR_BASE+SCR_SIZE).
REQ-006 The block SHALL have parameter TIMEOUT, default 1000, meaning the run-cycle limit (at least 1).
REQ-007 The block SHALL have parameter HIST_DEPTH, default 8, meaning the history ring-buffer depth (a power of two, at least 2).
REQ-008 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_write  in  1  write strobe.
- mem_read  in  1  read strobe.
- data_adr  in  ADDR_W  access address.
- write_data  in  DATA_W  write data.
- hist_idx  in  log2(HIST_DEPTH)  history read index; 0 = most recent write.
- status  out  2  state: 00 RUN, 01 PASS, 10 FAIL, 11 TMO.
- done  out  1  status != RUN.
- cycle_cnt  out  32  RUN cycles elapsed.
- write_cnt  out  16  accepted scratch writes, saturating at 16'hFFFF.
- fail_adr  out  ADDR_W  address of the offending access.
- fail_data  out  DATA_W  data of the offending access.
- hist_valid  out  1  hist_idx refers to a recorded write.
- hist_adr  out  ADDR_W  recorded address.
- hist_data  out  DATA_W  recorded data.

Function
REQ-009 The block SHALL sample inputs on the rising edge of clk, with registered outputs only and no combinational input-to-output path except the history read (REQ-017).
REQ-010 In RUN, cycle_cnt SHALL increment by 1 every cycle; in PASS, FAIL and TMO it SHALL hold.
REQ-011 In RUN, when mem_write=1 and mem_read=0 with data_adr==PASS_ADR and write_data==PASS_DATA, the block SHALL go to PASS next cycle.
REQ-012 In RUN, when mem_write=1, mem_read=0 and data_adr is inside the scratch window, the block SHALL stay in RUN and increment write_cnt.
REQ-013 In RUN, any other write SHALL go to FAIL, including PASS_ADR with wrong data; the block SHALL capture data_adr and write_data into fail_adr and fail_data.
REQ-014 In RUN, mem_write=1 together with mem_read=1 SHALL go to FAIL (protocol error), capturing the address and data.
REQ-015 When cycle_cnt==TIMEOUT-1 in RUN and no write resolves that cycle, the block SHALL go to TMO; a PASS or FAIL write in the same cycle SHALL take priority over TMO.
REQ-016 PASS, FAIL and TMO SHALL be sticky until reset; writes in those states SHALL change nothing.

Reset
REQ-018 While reset=0 at a rising edge, the block SHALL force: status=RUN, done=0, cycle_cnt=0, write_cnt=0, fail_adr=0, fail_data=0, history pointer and count=0, hist_valid=0.
REQ-019 Reset asserted mid-run or in a terminal state SHALL restart monitoring from the first cycle after release; history contents SHALL be invalidated by count only, not cleared.

Configuration
REQ-017 With MON_HIST_EN defined, every write sampled in RUN (all outcomes) SHALL be stored in a HIST_DEPTH ring buffer with a wrapping write pointer; hist_adr and hist_data SHALL read combinationally entry (ptr-1-hist_idx) mod HIST_DEPTH; hist_valid SHALL be 1 iff hist_idx < min(writes recorded, HIST_DEPTH).
REQ-020 With MON_HIST_EN undefined, the block SHALL instantiate no history storage and SHALL tie hist_valid, hist_adr and hist_data to 0; all other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL check: writes to 96, 97, 99, then (100, 25) -> status=01 one cycle later, write_cnt=3, done=1.
REQ-022 The bench SHALL check: write (100, 24) -> status=10, fail_adr=100, fail_data=24; a later (100, 25) leaves status=10.
REQ-023 The bench SHALL check: no writes with TIMEOUT=1000 -> status=11 after exactly 1000 RUN cycles, cycle_cnt=1000; with TIMEOUT=5, (100, 25) on cycle 4 -> status=01, not 11.
REQ-024 The bench SHALL check: mem_write=1 and mem_read=1 at address 96 -> status=10, fail_adr=96.
REQ-025 The bench SHALL check, with MON_HIST_EN and HIST_DEPTH=8: 10 scratch writes with data 1..10 -> hist_idx=0 gives data 10, hist_idx=7 gives data 3, all hist_valid=1; after reset, hist_valid=0 for every index.
REQ-026 The bench SHALL check: reset pulsed low for 1 cycle in PASS -> status=00, cycle_cnt=0, write_cnt=0 the next cycle.

Source files
------------

// File: rtl/mem_write_monitor.sv
// ============================================================================
// Module      : mem_write_monitor
// Description : Watches a memory write bus and reports PASS, FAIL or TIMEOUT.
//               Define MON_HIST_EN to keep a ring buffer of recent writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_write_monitor #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PASS_ADR   = 100,
    parameter int unsigned PASS_DATA  = 25,
    parameter int unsigned SCR_BASE   = 96,
    parameter int unsigned SCR_SIZE   = 4,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned HIST_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_write,
    input  logic                          mem_read,
    input  logic [ADDR_W-1:0]             data_adr,
    input  logic [DATA_W-1:0]             write_data,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [1:0]                    status,
    output logic                          done,
    output logic [31:0]                   cycle_cnt,
    output logic [15:0]                   write_cnt,
    output logic [ADDR_W-1:0]             fail_adr,
    output logic [DATA_W-1:0]             fail_data,
    output logic                          hist_valid,
    output logic [ADDR_W-1:0]             hist_adr,
    output logic [DATA_W-1:0]             hist_data
);

    localparam int unsigned HIDX_W = $clog2(HIST_DEPTH);

    localparam logic [63:0] C_SCR_LO  = 64'(SCR_BASE);
    localparam logic [63:0] C_SCR_HI  = 64'(SCR_BASE) + 64'(SCR_SIZE);
    localparam logic [31:0] C_TMO_CYC = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_PASS = 2'b01,
        ST_FAIL = 2'b10,
        ST_TMO  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         cycle_cnt_q, cycle_cnt_d;
    logic [15:0]         write_cnt_q, write_cnt_d;
    logic [ADDR_W-1:0]   fail_adr_q, fail_adr_d;
    logic [DATA_W-1:0]   fail_data_q, fail_data_d;

    logic                w_run_write;
    logic                w_is_pass;
    logic                w_in_scratch;
    logic [63:0]         w_adr_ext;

    assign w_adr_ext    = 64'(data_adr);
    assign w_run_write  = (state_q == ST_RUN) && mem_write;
    assign w_is_pass    = (data_adr == ADDR_W'(PASS_ADR)) && (write_data == DATA_W'(PASS_DATA));
    assign w_in_scratch = (w_adr_ext >= C_SCR_LO) && (w_adr_ext < C_SCR_HI);

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        write_cnt_d = write_cnt_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;

        if (state_q == ST_RUN) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            if (mem_write) begin
                if (mem_read) begin
                    state_d     = ST_FAIL;
                    fail_adr_d  = data_adr;
                    fail_data_d = write_data;
                end else if (w_is_pass) begin
                    state_d = ST_PASS;
                end else if (w_in_scratch) begin
                    if (write_cnt_q != 16'hFFFF) begin
                        write_cnt_d = write_cnt_q + 16'd1;
                    end
                end else begin
                    state_d     = ST_FAIL;
                    fail_adr_d  = data_adr;
                    fail_data_d = write_data;
                end
            end
            // A resolving write on the last cycle wins over the timeout.
            if ((state_d == ST_RUN) && (cycle_cnt_q == C_TMO_CYC)) begin
                state_d = ST_TMO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            cycle_cnt_q <= '0;
            write_cnt_q <= '0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            write_cnt_q <= write_cnt_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign status    = state_q;
    assign done      = (state_q != ST_RUN);
    assign cycle_cnt = cycle_cnt_q;
    assign write_cnt = write_cnt_q;
    assign fail_adr  = fail_adr_q;
    assign fail_data = fail_data_q;

`ifdef MON_HIST_EN
    logic [HIDX_W-1:0] hist_ptr_q, hist_ptr_d;
    logic [HIDX_W:0]   hist_cnt_q, hist_cnt_d;
    logic [ADDR_W-1:0] hist_adr_mem  [HIST_DEPTH];
    logic [DATA_W-1:0] hist_data_mem [HIST_DEPTH];
    logic [HIDX_W-1:0] w_rd_idx;

    always_comb begin
        hist_ptr_d = hist_ptr_q;
        hist_cnt_d = hist_cnt_q;
        if (w_run_write) begin
            hist_ptr_d = hist_ptr_q + 1'b1;
            if (hist_cnt_q != (HIDX_W+1)'(HIST_DEPTH)) begin
                hist_cnt_d = hist_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_ptr_q <= '0;
            hist_cnt_q <= '0;
        end else begin
            hist_ptr_q <= hist_ptr_d;
            hist_cnt_q <= hist_cnt_d;
        end
    end

    // Storage is not reset; the count alone marks entries as stale.
    always_ff @(posedge clk) begin
        if (reset && w_run_write) begin
            hist_adr_mem[hist_ptr_q]  <= data_adr;
            hist_data_mem[hist_ptr_q] <= write_data;
        end
    end

    assign w_rd_idx   = hist_ptr_q - 1'b1 - hist_idx;
    assign hist_valid = ({1'b0, hist_idx} < hist_cnt_q);
    assign hist_adr   = hist_adr_mem[w_rd_idx];
    assign hist_data  = hist_data_mem[w_rd_idx];
`else
    logic w_unused_hist;
    assign w_unused_hist = ^{hist_idx, w_run_write};
    assign hist_valid    = 1'b0;
    assign hist_adr      = '0;
    assign hist_data     = '0;
`endif

endmodule

`default_nettype wire
